// File: rtl/zx81_tape_pkg.sv
// zx81_tape_pkg: shared states, pulse phases and default cassette timing for the ZX81 tape player.
package zx81_tape_pkg;
    typedef enum logic [2:0] {IDLE, LEADER, NAME, FETCH, WAIT, BIT, NEXT, TRAILER} state_t;
    typedef enum logic [1:0] {PH_HI, PH_LO, PH_GAP} phase_t;
    localparam int unsigned DEF_HI_TICKS     = 488;
    localparam int unsigned DEF_LO_TICKS     = 488;
    localparam int unsigned DEF_GAP_TICKS    = 4225;
    localparam int unsigned DEF_LEADER_TICKS = 1625000;
    localparam logic [3:0]  PULSES_0         = 4'd4;
    localparam logic [3:0]  PULSES_1         = 4'd9;
    localparam logic [7:0]  NAME_BYTE        = 8'hA6;
endpackage

// File: rtl/zx81_tape_bit_gen.sv
// zx81_tape_bit_gen: plays one tape bit as a pulse train plus trailing gap, one level slot per ce tick.
module zx81_tape_bit_gen
    import zx81_tape_pkg::*;
#(
    parameter int unsigned HI_TICKS  = DEF_HI_TICKS,
    parameter int unsigned LO_TICKS  = DEF_LO_TICKS,
    parameter int unsigned GAP_TICKS = DEF_GAP_TICKS
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic clear,
    input  logic ce,
    input  logic load,
    input  logic bit_in,
    output logic tape_out,
    output logic bit_done
);
    phase_t      phase;
    logic        active;
    logic [31:0] cnt;
    logic [3:0]  pulses;
    logic        last;
    assign last = cnt == 32'd1;
    always_ff @(posedge clk_sys) begin
        if (reset || clear) begin
            active   <= 1'b0;
            phase    <= PH_HI;
            cnt      <= 32'd0;
            pulses   <= 4'd0;
            tape_out <= 1'b0;
            bit_done <= 1'b0;
        end else begin
            bit_done <= 1'b0;
            if (load) begin
                active <= 1'b1;
                phase  <= PH_HI;
                cnt    <= HI_TICKS;
                pulses <= bit_in ? PULSES_1 : PULSES_0;
            end else if (ce) begin
                tape_out <= active && phase == PH_HI;
                if (active && !last) cnt <= cnt - 32'd1;
                // Each phase holds its level for exactly its tick count, then hands over.
                if (active && last) begin
                    phase    <= phase == PH_HI ? PH_LO : (phase == PH_LO && pulses == 4'd1) ? PH_GAP : PH_HI;
                    cnt      <= phase == PH_HI ? LO_TICKS : phase == PH_LO ? (pulses == 4'd1 ? GAP_TICKS : HI_TICKS) : 32'd0;
                    pulses   <= phase == PH_LO ? pulses - 4'd1 : pulses;
                    active   <= phase != PH_GAP;
                    bit_done <= phase == PH_GAP;
                end
            end
        end
    end
endmodule

// File: rtl/zx81_tape_player.sv
// zx81_tape_player: plays a .P image from the tape buffer as a ZX81 cassette waveform.
// Define ZX81_TAPE_NAME_EN to emit NAME_BYTE as a synthetic program name after the leader.
module zx81_tape_player
    import zx81_tape_pkg::*;
#(
    parameter int unsigned HI_TICKS     = DEF_HI_TICKS,
    parameter int unsigned LO_TICKS     = DEF_LO_TICKS,
    parameter int unsigned GAP_TICKS    = DEF_GAP_TICKS,
    parameter int unsigned LEADER_TICKS = DEF_LEADER_TICKS
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce,
    input  logic        start,
    input  logic        stop,
    input  logic [13:0] tape_len,
    output logic [13:0] rd_addr,
    output logic        rd_en,
    input  logic [7:0]  rd_data,
    output logic        tape_out,
    output logic        busy,
    output logic        done
);
    state_t      state, state_nx;
    logic [31:0] timer;
    logic [13:0] len, byte_idx;
    logic [7:0]  shift;
    logic [2:0]  bit_cnt;
    logic        name_phase, load, bit_in, bit_done, timer_end;
    assign timer_end = ce && timer == 32'd1;
    assign rd_addr   = byte_idx;
    assign rd_en     = state == FETCH;
    assign busy      = state != IDLE;
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        bit_in   = 1'b0;
        case (state)
            IDLE:    state_nx = (start && tape_len != 14'd0) ? LEADER : IDLE;
`ifdef ZX81_TAPE_NAME_EN
            LEADER:  state_nx = timer_end ? NAME : LEADER;
`else
            LEADER:  state_nx = timer_end ? FETCH : LEADER;
`endif
            NAME: begin
                load     = 1'b1;
                bit_in   = NAME_BYTE[7];
                state_nx = BIT;
            end
            FETCH:   state_nx = WAIT;
            WAIT: begin
                load     = 1'b1;
                bit_in   = rd_data[7];
                state_nx = BIT;
            end
            BIT: begin
                load     = bit_done && bit_cnt != 3'd0;
                bit_in   = shift[6];
                state_nx = !bit_done ? BIT : bit_cnt != 3'd0 ? BIT : name_phase ? FETCH : NEXT;
            end
            NEXT:    state_nx = byte_idx == len - 14'd1 ? TRAILER : FETCH;
            TRAILER: state_nx = timer_end ? IDLE : TRAILER;
            default: state_nx = IDLE;
        endcase
        if (stop) begin
            state_nx = IDLE;
            load     = 1'b0;
        end
    end
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= 32'd0;
            len        <= 14'd0;
            byte_idx   <= 14'd0;
            shift      <= 8'd0;
            bit_cnt    <= 3'd0;
            name_phase <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= state == TRAILER && timer_end && !stop;
            // The same timer serves leader and trailer; it is preloaded on entry to either.
            timer <= ((state == IDLE && state_nx == LEADER) || state == NEXT) ? LEADER_TICKS :
                     (ce && timer != 32'd0) ? timer - 32'd1 : timer;
            if (state == IDLE) begin
                len        <= tape_len;
                byte_idx   <= 14'd0;
                name_phase <= 1'b0;
            end
            if (state == NAME) name_phase <= 1'b1;
            if (state == BIT && bit_done && bit_cnt == 3'd0) name_phase <= 1'b0;
            if (state == NEXT && state_nx == FETCH) byte_idx <= byte_idx + 14'd1;
            if (load) begin
                shift   <= state == WAIT ? rd_data : state == NAME ? NAME_BYTE : shift << 1;
                bit_cnt <= state == BIT ? bit_cnt - 3'd1 : 3'd7;
            end
        end
    end
    zx81_tape_bit_gen #(
        .HI_TICKS (HI_TICKS),
        .LO_TICKS (LO_TICKS),
        .GAP_TICKS(GAP_TICKS)
    ) u_bit_gen (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clear   (stop),
        .ce      (ce),
        .load    (load),
        .bit_in  (bit_in),
        .tape_out(tape_out),
        .bit_done(bit_done)
    );
endmodule
